// File: rtl/tankb_pkg.sv
// tankb_pkg: shared constants, ROM region map, FIFO word layout and writer
// state encoding for the ROM download path.
package tankb_pkg;

    localparam logic [7:0] ROM_INDEX = 8'd0;
    localparam int         IMG_BYTES = 10496;

    localparam logic [13:0] PRG_BASE  = 14'h0000;
    localparam logic [13:0] GFX_BASE  = 14'h2000;
    localparam logic [13:0] PROM_BASE = 14'h2800;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } dl_word_t;

endpackage

// File: rtl/rom_dl_writer_fifo.sv
// byte_fifo: small synchronous FIFO with flush.
// Ports: clk/reset, i_flush (drop all entries), i_push/i_din (write),
// i_pop (advance read), o_dout (head entry), o_full, o_empty,
// o_count (occupancy).
module byte_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/rom_dl_writer.sv
// rom_dl_writer: turns the framework ioctl byte stream into paced ROM writes
// and holds the core in reset until a complete, clean image has landed.
// Ports: clk/reset; ioctl_download/index/wr/addr/dout (sender stream),
// ioctl_wait (backpressure); dn_addr/dn_data/dn_wr (ROM write port);
// core_reset_n, rom_ready, dl_error (load status).
module rom_dl_writer #(
    parameter logic [7:0] ROM_INDEX  = tankb_pkg::ROM_INDEX,
    parameter int         IMG_BYTES  = tankb_pkg::IMG_BYTES,
    parameter int         WR_HOLD    = 2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset_n,
    output logic        rom_ready,
    output logic        dl_error
);

    import tankb_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t      r_state;
    logic        r_dl_d;
    logic [14:0] r_count;
    logic        r_overflow;
    logic        r_range_err;
    logic        r_pend;
    dl_word_t    r_pword;
    logic [2:0]  r_hold;
    logic        r_wait;
    logic [13:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic        r_dn_wr;
    logic        r_core_reset_n;
    logic        r_rom_ready;
    logic        r_dl_error;

    logic          w_start;
    logic          w_match;
    logic          w_inrange;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ok;
    logic [CW-1:0] w_occ;
    dl_word_t      w_dout;

    // Bytes are only taken once a ROM download has been started, so a
    // download left high across reset cannot fill a FIFO nobody drains.
    assign w_start   = ioctl_download && !r_dl_d && ioctl_index == ROM_INDEX;
    assign w_match   = ioctl_wr && ioctl_download && ioctl_index == ROM_INDEX && r_state != IDLE && !w_start;
    assign w_inrange = ioctl_addr < 25'(IMG_BYTES);
    assign w_push    = w_match && w_inrange && !w_full;
    // Prefetch the next entry while the current write is still held.
    assign w_pop     = (r_state == LOAD || r_state == WRITE) && !r_pend && !w_empty && !w_start;
    assign w_ok      = r_count == 15'(IMG_BYTES) && !r_overflow && !r_range_err;

    byte_fifo #(.W($bits(dl_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_din   ({ioctl_addr[13:0], ioctl_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_dl_d         <= 1'b0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_range_err    <= 1'b0;
            r_pend         <= 1'b0;
            r_pword        <= '0;
            r_hold         <= '0;
            r_wait         <= 1'b0;
            r_dn_addr      <= '0;
            r_dn_data      <= '0;
            r_dn_wr        <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_rom_ready    <= 1'b0;
            r_dl_error     <= 1'b0;
        end else begin
            r_dl_d <= ioctl_download;
            // Based on the post-edge occupancy so a sender reacting one
            // cycle late still finds a free slot.
            r_wait <= !w_start && (int'(w_occ) + int'(w_push) - int'(w_pop) >= FIFO_DEPTH - 1);
            if (w_start) begin
                r_count        <= '0;
                r_overflow     <= 1'b0;
                r_range_err    <= 1'b0;
                r_pend         <= 1'b0;
                r_rom_ready    <= 1'b0;
                r_core_reset_n <= 1'b0;
            end else begin
                if (w_push && r_count != '1) r_count <= r_count + 1'b1;
                if (w_match && w_inrange && w_full) r_overflow <= 1'b1;
                if (w_match && !w_inrange) r_range_err <= 1'b1;
                if (w_pop) begin
                    r_pend  <= 1'b1;
                    r_pword <= w_dout;
                end
            end
            case (r_state)
                IDLE: if (w_start) r_state <= LOAD;
                LOAD: begin
                    if (r_pend && !w_start) begin
                        r_dn_addr <= r_pword.addr;
                        r_dn_data <= r_pword.data;
                        r_dn_wr   <= 1'b1;
                        r_hold    <= 3'd1;
                        r_pend    <= 1'b0;
                        r_state   <= WRITE;
                    end else if (!ioctl_download && w_empty && !r_pend) begin
                        r_state <= DONE;
                    end
                end
                WRITE: begin
                    if (r_hold == 3'(WR_HOLD)) begin
                        r_dn_wr <= 1'b0;
                        r_state <= LOAD;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                DONE: begin
                    r_rom_ready    <= w_ok;
                    r_dl_error     <= !w_ok;
                    r_core_reset_n <= w_ok;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ioctl_wait   = r_wait;
    assign dn_addr      = r_dn_addr;
    assign dn_data      = r_dn_data;
    assign dn_wr        = r_dn_wr;
    assign core_reset_n = r_core_reset_n;
    assign rom_ready    = r_rom_ready;
    assign dl_error     = r_dl_error;

endmodule

// File: tb/tb_rom_dl_writer.sv
// tb_rom_dl_writer: directed self-checking bench for rom_dl_writer.
module tb_rom_dl_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset_n;
    logic        rom_ready;
    logic        dl_error;

    int tests = 0;
    int fails = 0;

    int pulses = 0;
    int len_bad = 0;
    int data_bad = 0;
    int hits_2900 = 0;
    int wait_rises = 0;
    int hi_len = 0;
    logic        prev_wr = 1'b0;
    logic        prev_wait = 1'b0;
    logic [13:0] prev_addr = '0;
    logic [13:0] last_addr = '0;
    logic [7:0]  last_data = '0;

    localparam int IMG = 10496;

    rom_dl_writer dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset_n   (core_reset_n),
        .rom_ready      (rom_ready),
        .dl_error       (dl_error)
    );

    always #5 clk = ~clk;

    // Write-port monitor: pulse count, pulse width, data pattern, stability.
    always @(negedge clk) begin
        if (dn_wr && !prev_wr) begin
            pulses++;
            last_addr = dn_addr;
            last_data = dn_data;
            if (dn_addr == 14'h2900) hits_2900++;
            if (dn_data != dn_addr[7:0]) data_bad++;
        end
        if (dn_wr && prev_wr && dn_addr != prev_addr) data_bad++;
        if (!dn_wr && prev_wr && hi_len != 2) len_bad++;
        hi_len = dn_wr ? hi_len + 1 : 0;
        if (ioctl_wait && !prev_wait) wait_rises++;
        prev_wr   = dn_wr;
        prev_addr = dn_addr;
        prev_wait = ioctl_wait;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int a, input int gap, input bit honor);
        int g = 0;
        if (honor) begin
            while (ioctl_wait && g < 100) begin
                tick();
                g++;
            end
            if (g >= 100) chk("wait_bound", g, 0);
        end
        ioctl_addr = 25'(a);
        ioctl_dout = 8'(a);
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        repeat (40) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wait"}, ioctl_wait, 0);
        chk({tag, "_addr"}, dn_addr, 0);
        chk({tag, "_data"}, dn_data, 0);
        chk({tag, "_wr"}, dn_wr, 0);
        chk({tag, "_crn"}, core_reset_n, 0);
        chk({tag, "_ready"}, rom_ready, 0);
        chk({tag, "_err"}, dl_error, 0);
    endtask

    initial begin
        int p0, l0, d0, h0, w0, g;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Full load, one byte every 3 cycles (matches drain rate).
        p0 = pulses; l0 = len_bad; d0 = data_bad;
        start_dl(8'd0);
        chk("t1_crn_loading", core_reset_n, 0);
        for (int a = 0; a < IMG; a++) send(a, 3, 1'b0);
        end_dl();
        chk("t1_pulses", pulses - p0, IMG);
        chk("t1_len", len_bad - l0, 0);
        chk("t1_data", data_bad - d0, 0);
        chk("t1_last_addr", last_addr, 14'h28FF);
        chk("t1_last_data", last_data, 8'hFF);
        chk("t1_ready", rom_ready, 1);
        chk("t1_err", dl_error, 0);
        chk("t1_crn", core_reset_n, 1);

        // Other-index transfer leaves everything alone.
        p0 = pulses;
        start_dl(8'd1);
        for (int a = 0; a < 8; a++) send(a, 3, 1'b0);
        end_dl();
        chk("t5_pulses", pulses - p0, 0);
        chk("t5_ready", rom_ready, 1);
        chk("t5_crn", core_reset_n, 1);
        chk("t5_err", dl_error, 0);

        // Short load; also first-byte latency.
        p0 = pulses;
        start_dl(8'd0);
        chk("t3_ready_cleared", rom_ready, 0);
        chk("t3_crn_cleared", core_reset_n, 0);
        send(0, 1, 1'b0);
        chk("t3_lat0", dn_wr, 0);
        tick();
        chk("t3_lat1", dn_wr, 0);
        tick();
        chk("t3_lat2", dn_wr, 1);
        chk("t3_lat_addr", dn_addr, 0);
        repeat (3) tick();
        for (int a = 1; a < 256; a++) send(a, 3, 1'b0);
        end_dl();
        chk("t3_pulses", pulses - p0, 256);
        chk("t3_ready", rom_ready, 0);
        chk("t3_err", dl_error, 1);
        chk("t3_crn", core_reset_n, 0);

        // Out-of-range byte at 0x2900 is never written.
        p0 = pulses; h0 = hits_2900;
        start_dl(8'd0);
        send(14'h28FE, 3, 1'b0);
        send(14'h28FF, 3, 1'b0);
        send(14'h2900, 3, 1'b0);
        end_dl();
        chk("t4_pulses", pulses - p0, 2);
        chk("t4_no_2900", hits_2900 - h0, 0);
        chk("t4_last_addr", last_addr, 14'h28FF);
        chk("t4_err", dl_error, 1);
        chk("t4_ready", rom_ready, 0);

        // Reset while writing 0x0100.
        start_dl(8'd0);
        for (int a = 0; a <= 256; a++) send(a, 3, 1'b0);
        g = 0;
        while (!(dn_wr && dn_addr == 14'h0100) && g < 20) begin
            tick();
            g++;
        end
        chk("t6_found", g < 20, 1);
        reset = 1'b1;
        tick();
        chk_reset_vals("t6");
        reset = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) tick();

        // Burst every cycle honouring ioctl_wait, then full success.
        p0 = pulses; l0 = len_bad; d0 = data_bad; w0 = wait_rises;
        start_dl(8'd0);
        for (int a = 0; a < IMG; a++) send(a, 1, 1'b1);
        end_dl();
        chk("t2_wait_seen", wait_rises > w0, 1);
        chk("t2_pulses", pulses - p0, IMG);
        chk("t2_len", len_bad - l0, 0);
        chk("t2_data", data_bad - d0, 0);
        chk("t2_last_addr", last_addr, 14'h28FF);
        chk("t2_ready", rom_ready, 1);
        chk("t2_err", dl_error, 0);
        chk("t2_crn", core_reset_n, 1);
        chk("t2_wait_idle", ioctl_wait, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
